// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request/response and ALU signal bundle for alu_share_arbiter
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_f;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_r;
    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_f;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_r;
    logic [2:0]       alu_f;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_r;
    logic             busy;

    // Requesters and the ALU instance side
    modport master (
        output req0_valid, req0_f, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_f, req1_a, req1_b, rsp1_ready,
        output alu_r,
        input  req0_ready, rsp0_valid, rsp0_r,
        input  req1_ready, rsp1_valid, rsp1_r,
        input  alu_f, alu_a, alu_b, busy
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_f, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_f, req1_a, req1_b, rsp1_ready,
        input  alu_r,
        output req0_ready, rsp0_valid, rsp0_r,
        output req1_ready, rsp1_valid, rsp1_r,
        output alu_f, alu_a, alu_b, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arbiter_if.slave   bus
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             prio_q, prio_d;
    logic             owner_q, owner_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       alu_f_q, alu_f_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [WIDTH-1:0] rsp0_r_q, rsp0_r_d;
    logic [WIDTH-1:0] rsp1_r_q, rsp1_r_d;
    logic             gnt0, gnt1;
    logic             rsp_ack;

    // Grant: a lone valid requester wins; prio breaks a tie (prio=1 favours requester 1)
    always_comb begin
        gnt1 = bus.req1_valid && (!bus.req0_valid || prio_q);
        gnt0 = bus.req0_valid && !gnt1;
    end

    // Next-state: accept in IDLE, hold operands for SETTLE cycles, capture, wait for consumer
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        alu_f_d  = alu_f_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        rsp0_r_d = rsp0_r_q;
        rsp1_r_d = rsp1_r_q;
        rsp_ack  = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
        case (state_q)
            ST_IDLE: begin
                if (gnt0 || gnt1) begin
                    owner_d = gnt1;
                    alu_f_d = gnt1 ? bus.req1_f : bus.req0_f;
                    alu_a_d = gnt1 ? bus.req1_a : bus.req0_a;
                    alu_b_d = gnt1 ? bus.req1_b : bus.req0_b;
                    cnt_d   = CW'(SETTLE);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (owner_q) begin
                        rsp1_r_d = bus.alu_r;
                    end else begin
                        rsp0_r_d = bus.alu_r;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ack) begin
                    prio_d  = ~owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset drops any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            cnt_q    <= '0;
            alu_f_q  <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            rsp0_r_q <= '0;
            rsp1_r_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            alu_f_q  <= alu_f_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            rsp0_r_q <= rsp0_r_d;
            rsp1_r_q <= rsp1_r_d;
        end
    end

    assign bus.req0_ready = (state_q == ST_IDLE) && gnt0;
    assign bus.req1_ready = (state_q == ST_IDLE) && gnt1;
    assign bus.rsp0_valid = (state_q == ST_RESP) && !owner_q;
    assign bus.rsp1_valid = (state_q == ST_RESP) && owner_q;
    assign bus.rsp0_r     = rsp0_r_q;
    assign bus.rsp1_r     = rsp1_r_q;
    assign bus.alu_f      = alu_f_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule
